despachador_divisor: RTL and testbench

- Operand dispatcher that sits directly upstream of the non-segmented divider (divisor_top).
- Buffers incoming numerator/denominator pairs in a small FIFO and drives the divider's START/NUMERADOR/DENOMINADOR for one operation at a time.
- Waits for DONE, captures COC/RES and presents them downstream with a valid/ready handshake.
- Handles division by zero itself, without involving the divider.

---
 rtl/pkg_divisor.sv | 28 ++
 rtl/fifo_operandos.sv | 76 +++++++
 rtl/despachador_divisor.sv | 140 ++++++++++++++
 tb/tb_despachador_divisor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_divisor.sv
// Shared definitions for the divider operand dispatcher.
//   estado_desp_t    : dispatcher FSM state encoding.
//   par_operandos_t  : operand pair {num, den} at the default operand width.
//                      Modules built with a different SIZE declare the same
//                      layout locally at their own width.
//   ancho_cuenta()   : width of an occupancy counter able to hold 0..depth.
package pkg_divisor;

  localparam int unsigned SIZE_DEF  = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARRANQUE = 2'd1,
    ESPERA   = 2'd2,
    SALIDA   = 2'd3
  } estado_desp_t;

  typedef struct packed {
    logic [SIZE_DEF-1:0] num;
    logic [SIZE_DEF-1:0] den;
  } par_operandos_t;

  function automatic int unsigned ancho_cuenta(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_operandos.sv
// Operand-pair FIFO feeding the dispatcher.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   push, push_num/den  write request and operand pair (ignored while full)
//   pop                 remove the head entry (ignored while empty)
//   head_num/den        current head entry
//   full, empty         status flags
//   ocupacion           number of stored entries
module fifo_operandos
  import pkg_divisor::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [SIZE-1:0]                  push_num,
  input  logic [SIZE-1:0]                  push_den,
  input  logic                             pop,
  output logic [SIZE-1:0]                  head_num,
  output logic [SIZE-1:0]                  head_den,
  output logic                             full,
  output logic                             empty,
  output logic [ancho_cuenta(DEPTH)-1:0]   ocupacion
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = ancho_cuenta(DEPTH);

  typedef struct packed {
    logic [SIZE-1:0] num;
    logic [SIZE-1:0] den;
  } par_t;

  par_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cuenta_q;
  logic            push_en;
  logic            pop_en;

  assign full      = (cuenta_q == CW'(DEPTH));
  assign empty     = (cuenta_q == '0);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head_num  = mem_q[rd_ptr_q].num;
  assign head_den  = mem_q[rd_ptr_q].den;
  assign ocupacion = cuenta_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cuenta_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= '{num: push_num, den: push_den};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_en && !pop_en) begin
        cuenta_q <= cuenta_q + CW'(1);
      end else if (pop_en && !push_en) begin
        cuenta_q <= cuenta_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/despachador_divisor.sv
// Operand dispatcher placed in front of the non-segmented divider.
// Queues operand pairs, runs one division at a time on the divider,
// resolves division by zero locally, and offers results on a valid/ready port.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   in_valid/in_ready           operand handshake (in_ready = !full)
//   in_num, in_den              operand pair
//   div_start                   one-cycle start pulse to the divider
//   div_num, div_den            operands held stable for the divider
//   div_coc, div_res, div_done  divider results and completion
//   out_valid/out_ready         result handshake
//   out_coc, out_res, out_dz    quotient, remainder, division-by-zero flag
//   ocupacion                   FIFO entry count
module despachador_divisor
  import pkg_divisor::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIZE-1:0]                  in_num,
  input  logic [SIZE-1:0]                  in_den,
  output logic                             div_start,
  output logic [SIZE-1:0]                  div_num,
  output logic [SIZE-1:0]                  div_den,
  input  logic [SIZE-1:0]                  div_coc,
  input  logic [SIZE-1:0]                  div_res,
  input  logic                             div_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0]                  out_coc,
  output logic [SIZE-1:0]                  out_res,
  output logic                             out_dz,
  output logic [ancho_cuenta(DEPTH)-1:0]   ocupacion
);

  estado_desp_t    estado_q;
  logic            div_start_q;
  logic [SIZE-1:0] div_num_q;
  logic [SIZE-1:0] div_den_q;
  logic            out_valid_q;
  logic [SIZE-1:0] out_coc_q;
  logic [SIZE-1:0] out_res_q;
  logic            out_dz_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [SIZE-1:0] head_num;
  logic [SIZE-1:0] head_den;

  // The head is consumed the same cycle IDLE decides what to do with it.
  assign fifo_pop = (estado_q == IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;

  fifo_operandos #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_num  (in_num),
    .push_den  (in_den),
    .pop       (fifo_pop),
    .head_num  (head_num),
    .head_den  (head_den),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ocupacion (ocupacion)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      div_start_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      out_valid_q <= 1'b0;
      out_coc_q   <= '0;
      out_res_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_den != '0) begin
              div_num_q   <= head_num;
              div_den_q   <= head_den;
              div_start_q <= 1'b1;
              estado_q    <= ARRANQUE;
            end else begin
              // Zero denominator: answer directly, divider stays idle.
              out_coc_q   <= '1;
              out_res_q   <= head_num;
              out_dz_q    <= 1'b1;
              out_valid_q <= 1'b1;
              estado_q    <= SALIDA;
            end
          end
        end
        ARRANQUE: begin
          // div_done is deliberately not looked at while the pulse is out.
          div_start_q <= 1'b0;
          estado_q    <= ESPERA;
        end
        ESPERA: begin
          if (div_done) begin
            out_coc_q   <= div_coc;
            out_res_q   <= div_res;
            out_dz_q    <= 1'b0;
            out_valid_q <= 1'b1;
            estado_q    <= SALIDA;
          end
        end
        SALIDA: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            estado_q    <= IDLE;
          end
        end
        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  assign div_start = div_start_q;
  assign div_num   = div_num_q;
  assign div_den   = div_den_q;
  assign out_valid = out_valid_q;
  assign out_coc   = out_coc_q;
  assign out_res   = out_res_q;
  assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_despachador_divisor.sv
// Directed bench for despachador_divisor with a 9-cycle behavioural divider.
module tb_despachador_divisor;

  localparam int unsigned SIZE = 8;
  localparam int unsigned DEPTH = 4;
  localparam int LAT = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_num = '0;
  logic [SIZE-1:0] in_den = '0;
  logic            div_start;
  logic [SIZE-1:0] div_num;
  logic [SIZE-1:0] div_den;
  logic [SIZE-1:0] div_coc;
  logic [SIZE-1:0] div_res;
  logic            div_done;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] out_coc;
  logic [SIZE-1:0] out_res;
  logic            out_dz;
  logic [2:0]      ocupacion;

  logic            model_done;
  logic            spur_done = 1'b0;
  int              cnt;
  logic [SIZE-1:0] lat_num;
  logic [SIZE-1:0] lat_den;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  int sb;
  int vb;
  int unstable;

  always #5 clk = ~clk;

  despachador_divisor #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .div_start (div_start),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_coc   (div_coc),
    .div_res   (div_res),
    .div_done  (div_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coc   (out_coc),
    .out_res   (out_res),
    .out_dz    (out_dz),
    .ocupacion (ocupacion)
  );

  assign div_done = model_done | spur_done;

  // Behavioural divider: done pulses LAT cycles after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 0;
      model_done <= 1'b0;
      div_coc    <= '0;
      div_res    <= '0;
      lat_num    <= '0;
      lat_den    <= '0;
    end else begin
      model_done <= 1'b0;
      if (div_start) begin
        cnt     <= LAT;
        lat_num <= div_num;
        lat_den <= div_den;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          model_done <= 1'b1;
          div_coc    <= lat_num / lat_den;
          div_res    <= lat_num % lat_den;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (out_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge performs the push.
  task automatic push(input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    chk("push_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_div_start"}, {31'b0, div_start}, 32'd0);
    chk({tag, "_div_num"}, {24'b0, div_num}, 32'd0);
    chk({tag, "_div_den"}, {24'b0, div_den}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out_coc"}, {24'b0, out_coc}, 32'd0);
    chk({tag, "_out_res"}, {24'b0, out_res}, 32'd0);
    chk({tag, "_out_dz"}, {31'b0, out_dz}, 32'd0);
    chk({tag, "_ocupacion"}, {29'b0, ocupacion}, 32'd0);
  endtask

  logic [SIZE-1:0] f_num [5] = '{8'd100, 8'd99, 8'd17, 8'd0, 8'd255};
  logic [SIZE-1:0] f_den [5] = '{8'd10, 8'd4, 8'd17, 8'd3, 8'd1};
  logic [SIZE-1:0] f_coc [5] = '{8'd10, 8'd24, 8'd1, 8'd0, 8'd255};
  logic [SIZE-1:0] f_res [5] = '{8'd0, 8'd3, 8'd0, 8'd0, 8'd0};

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single operation 200/7.
    out_ready = 1'b1;
    sb = start_cnt;
    vb = valid_cnt;
    push(8'd200, 8'd7);
    chk("single_start_n1", {31'b0, div_start}, 32'd0);
    @(negedge clk);
    chk("single_start_n2", {31'b0, div_start}, 32'd1);
    chk("single_div_num", {24'b0, div_num}, 32'd200);
    chk("single_div_den", {24'b0, div_den}, 32'd7);
    @(negedge clk);
    chk("single_start_n3", {31'b0, div_start}, 32'd0);
    wait_valid("single_valid_timeout");
    chk("single_coc", {24'b0, out_coc}, 32'd28);
    chk("single_res", {24'b0, out_res}, 32'd4);
    chk("single_dz", {31'b0, out_dz}, 32'd0);
    @(negedge clk);
    chk("single_valid_drop", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("single_start_count", start_cnt - sb, 32'd1);
    chk("single_valid_count", valid_cnt - vb, 32'd1);

    // Division by zero 55/0.
    sb = start_cnt;
    push(8'd55, 8'd0);
    chk("dz_valid_n1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("dz_valid_n2", {31'b0, out_valid}, 32'd1);
    chk("dz_coc", {24'b0, out_coc}, 32'hFF);
    chk("dz_res", {24'b0, out_res}, 32'd55);
    chk("dz_flag", {31'b0, out_dz}, 32'd1);
    repeat (3) @(negedge clk);
    chk("dz_no_start", start_cnt - sb, 32'd0);

    // Fill, backpressure and ordering.
    out_ready = 1'b0;
    sb = start_cnt;
    for (int i = 0; i < 5; i++) begin
      push(f_num[i], f_den[i]);
    end
    chk("fill_ocupacion", {29'b0, ocupacion}, 32'd4);
    chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_num   = 8'd77;
    in_den   = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_blocked", {29'b0, ocupacion}, 32'd4);
    wait_valid("bp_valid_timeout");
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_coc !== 8'd10 || out_res !== 8'd0 || out_dz !== 1'b0)
        unstable++;
    end
    chk("bp_stable", unstable, 32'd0);
    chk("bp_one_start", start_cnt - sb, 32'd1);
    chk("bp_ocupacion", {29'b0, ocupacion}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("order%0d_timeout", i));
      chk($sformatf("order%0d_coc", i), {24'b0, out_coc}, {24'b0, f_coc[i]});
      chk($sformatf("order%0d_res", i), {24'b0, out_res}, {24'b0, f_res[i]});
      chk($sformatf("order%0d_dz", i), {31'b0, out_dz}, 32'd0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("order_empty", {29'b0, ocupacion}, 32'd0);

    // Spurious done in IDLE and in ARRANQUE.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("spur_idle_start", {31'b0, div_start}, 32'd0);
    push(8'd9, 8'd3);
    @(negedge clk);
    chk("spur_arr_start", {31'b0, div_start}, 32'd1);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_arr_valid", {31'b0, out_valid}, 32'd0);
    wait_valid("spur_valid_timeout");
    chk("spur_coc", {24'b0, out_coc}, 32'd3);
    chk("spur_res", {24'b0, out_res}, 32'd0);
    repeat (3) @(negedge clk);

    // Reset during ESPERA with three entries queued.
    out_ready = 1'b0;
    push(8'd50, 8'd5);
    push(8'd60, 8'd6);
    push(8'd70, 8'd7);
    push(8'd80, 8'd8);
    chk("mid_ocupacion", {29'b0, ocupacion}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sb = start_cnt;
    repeat (3) @(negedge clk);
    chk("post_rst_no_start", start_cnt - sb, 32'd0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    push(8'd9, 8'd2);
    wait_valid("post_rst_timeout");
    chk("post_rst_coc", {24'b0, out_coc}, 32'd4);
    chk("post_rst_res", {24'b0, out_res}, 32'd1);
    chk("post_rst_one_start", start_cnt - sb, 32'd1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
